aes_inv_cipher_iter: RTL

Iterative AES inverse cipher that decrypts one 128-bit block at one round per clock. It is the decryption counterpart of the forward round datapath and applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns in FIPS-197 inverse-cipher order. Round keys come from an external key store through an index/data port. It sits between the ciphertext source and the plaintext consumer, with valid/ready handshakes on both sides.

---
 rtl/aes_pkg.sv | 94 +++++++++
 rtl/aes_inv_cipher_iter_if.sv | 34 +++
 rtl/inv_shift_rows.sv | 17 +
 rtl/aes_inv_cipher_iter.sv | 102 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: inverse S-box, GF(2^8) helpers,
// FSM state encoding, round-count constants and column-major byte indexing.
package aes_pkg;

    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } aes_state_t;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // MSB position of the byte at (row r, column c) in a 128-bit state.
    function automatic int byte_msb(input int r, input int c);
        return 127 - 8 * (4 * c + r);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gf_xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    // One column, row 0 in the most significant byte.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        r1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        r2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        r3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        return {r0, r1, r2, r3};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[byte_msb(0, c) -: 32] = inv_mix_column(s[byte_msb(0, c) -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and data bus of the iterative AES inverse cipher: ciphertext in,
// round-key lookup, plaintext out. The slave modport is the cipher itself.
interface aes_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  rk_idx,
        output rk_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output rk_idx,
        input  rk_data,
        output out_valid,
        input  out_ready,
        output out_data
    );
endinterface

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows: row r of the column-major state is rotated right by r bytes.
module inv_shift_rows
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int DST = byte_msb(r, c);
            localparam int SRC = byte_msb(r, (c - r + 4) % 4);
            assign dout[DST -: 8] = din[SRC -: 8];
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched from an
// external store through rk_idx/rk_data.
// Optional build macro AES_INV_ZEROIZE_EN: clears the state register on the
// output handshake so no plaintext lingers on out_data while idle.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_cipher_iter_if.slave bus
);

    if (NR != AES_NR_128 && NR != AES_NR_192 && NR != AES_NR_256) begin : g_bad_nr
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    aes_state_t   fsm;
    logic [3:0]   cnt;
    logic [127:0] state_q;
    logic         in_ready_q;
    logic         out_valid_q;

    logic [127:0] shifted;
    logic [127:0] sub_xor;
    logic [127:0] round_out;
    logic [3:0]   rk_idx_c;

    inv_shift_rows u_inv_shift_rows (
        .din  (state_q),
        .dout (shifted)
    );

    // Shared round datapath: LAST uses sub_xor, ROUND adds InvMixColumns on top.
    assign sub_xor   = inv_sub_bytes(shifted) ^ bus.rk_data;
    assign round_out = inv_mix_columns(sub_xor);

    // Key index depends only on FSM state and round counter.
    always_comb begin
        rk_idx_c = 4'd0;
        case (fsm)
            IDLE:    rk_idx_c = 4'(NR);
            ROUND:   rk_idx_c = cnt;
            default: rk_idx_c = 4'd0;
        endcase
    end

    // Round sequencing, state register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            cnt         <= 4'd0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q    <= bus.in_data ^ bus.rk_data;
                        cnt        <= 4'(NR - 1);
                        in_ready_q <= 1'b0;
                        fsm        <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    if (cnt == 4'd1) begin
                        fsm <= LAST;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                LAST: begin
                    state_q     <= sub_xor;
                    out_valid_q <= 1'b1;
                    fsm         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm         <= IDLE;
`ifdef AES_INV_ZEROIZE_EN
                        state_q     <= '0;
`else
                        state_q     <= state_q;
`endif
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = state_q;
    assign bus.rk_idx    = rk_idx_c;

endmodule
